// File: rtl/cpu_trace_checker.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_checker
// Purpose  : Compares a CPU observation bus (PC/INST/R) against a preloaded
//            golden trace and reports pass/fail plus the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_checker #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int WARMUP  = 1,
  parameter int CHECK_R = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   PC,
  input  logic [31:0]   INST,
  input  logic [31:0]   R,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [31:0]   WPC,
  input  logic [31:0]   WINST,
  input  logic [31:0]   WR,
  input  logic [AW:0]   LEN,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic          FAIL,
  output logic [AW-1:0] ERR_IDX,
  output logic [2:0]    ERR_FIELD,
  output logic [31:0]   ERR_PC,
  output logic [15:0]   CYCLES
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CHECK  = 3'd2,
    S_PASSED = 3'd3,
    S_FAILED = 3'd4
  } state_t;

  localparam logic [AW:0] C_DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [15:0] C_WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   warm_q, warm_d;
  logic [15:0]   cycles_q, cycles_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic [2:0]    err_field_q, err_field_d;
  logic [31:0]   err_pc_q, err_pc_d;
  logic          busy_q, done_q, pass_q, fail_q;

  logic [95:0]   mem [DEPTH];
  logic [95:0]   entry;
  logic [2:0]    mis;
  logic [AW:0]   len_clip;
  logic          can_start;

  assign can_start = (state_q == S_IDLE) || (state_q == S_PASSED) || (state_q == S_FAILED);
  assign len_clip  = (LEN > C_DEPTH_W) ? C_DEPTH_W : LEN;
  assign entry     = mem[idx_q];

  // Entry layout is {R, INST, PC}; mismatch mask keeps the same field order.
  assign mis[0] = (PC   != entry[31:0]);
  assign mis[1] = (INST != entry[63:32]);
  assign mis[2] = (CHECK_R != 0) && (R != entry[95:64]);

  // Trace memory has no reset so a mid-run reset keeps the loaded trace.
  always_ff @(posedge CLK) begin
    if (WE && can_start && ({1'b0, WADDR} < C_DEPTH_W)) begin
      mem[WADDR] <= {WR, WINST, WPC};
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    warm_d      = warm_q;
    cycles_d    = cycles_q;
    err_idx_d   = err_idx_q;
    err_field_d = err_field_q;
    err_pc_d    = err_pc_q;
    case (state_q)
      S_WAIT: begin
        if (warm_q == C_WARM_LAST) begin
          state_d = S_CHECK;
          warm_d  = 16'd0;
        end else begin
          warm_d = warm_q + 16'd1;
        end
      end
      S_CHECK: begin
        if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
        if (|mis) begin
          state_d     = S_FAILED;
          err_idx_d   = idx_q;
          err_field_d = mis;
          err_pc_d    = PC;
        end else if ({1'b0, idx_q} == (len_q - 1'b1)) begin
          state_d = S_PASSED;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        if (START) begin
          len_d       = len_clip;
          idx_d       = '0;
          warm_d      = 16'd0;
          cycles_d    = 16'd0;
          err_idx_d   = '0;
          err_field_d = 3'd0;
          err_pc_d    = 32'd0;
          if (len_clip == '0)  state_d = S_PASSED;
          else if (WARMUP > 0) state_d = S_WAIT;
          else                 state_d = S_CHECK;
        end
      end
    endcase
  end

  // Status flags are decoded from the next state so they line up with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      warm_q      <= 16'd0;
      cycles_q    <= 16'd0;
      err_idx_q   <= '0;
      err_field_q <= 3'd0;
      err_pc_q    <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      warm_q      <= warm_d;
      cycles_q    <= cycles_d;
      err_idx_q   <= err_idx_d;
      err_field_q <= err_field_d;
      err_pc_q    <= err_pc_d;
      busy_q      <= (state_d == S_WAIT)   || (state_d == S_CHECK);
      done_q      <= (state_d == S_PASSED) || (state_d == S_FAILED);
      pass_q      <= (state_d == S_PASSED);
      fail_q      <= (state_d == S_FAILED);
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL      = fail_q;
  assign ERR_IDX   = err_idx_q;
  assign ERR_FIELD = err_field_q;
  assign ERR_PC    = err_pc_q;
  assign CYCLES    = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_trace_checker
// Purpose  : Directed self-checking bench for cpu_trace_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, inst, r;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wpc, winst, wr;
  logic [5:0]  len;
  logic        start;

  logic        busy_a, done_a, pass_a, fail_a;
  logic [4:0]  err_idx_a;
  logic [2:0]  err_field_a;
  logic [31:0] err_pc_a;
  logic [15:0] cycles_a;

  logic        busy_b, done_b, pass_b, fail_b;
  logic [4:0]  err_idx_b;
  logic [2:0]  err_field_b;
  logic [31:0] err_pc_b;
  logic [15:0] cycles_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Main instance: one warm-up edge, R compared.
  cpu_trace_checker #(.DEPTH(32), .AW(5), .WARMUP(1), .CHECK_R(1)) dut (
    .CLK(clk), .RST(rst), .PC(pc), .INST(inst), .R(r),
    .WE(we), .WADDR(waddr), .WPC(wpc), .WINST(winst), .WR(wr),
    .LEN(len), .START(start),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .FAIL(fail_a),
    .ERR_IDX(err_idx_a), .ERR_FIELD(err_field_a), .ERR_PC(err_pc_a), .CYCLES(cycles_a)
  );

  // Second instance: no warm-up, R ignored.
  cpu_trace_checker #(.DEPTH(32), .AW(5), .WARMUP(0), .CHECK_R(0)) dut_nr (
    .CLK(clk), .RST(rst), .PC(pc), .INST(inst), .R(r),
    .WE(we), .WADDR(waddr), .WPC(wpc), .WINST(winst), .WR(wr),
    .LEN(len), .START(start),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .FAIL(fail_b),
    .ERR_IDX(err_idx_b), .ERR_FIELD(err_field_b), .ERR_PC(err_pc_b), .CYCLES(cycles_b)
  );

  function automatic logic [31:0] epc(input int i);
    return 32'(4 * i);
  endfunction
  function automatic logic [31:0] einst(input int i);
    return 32'h0022_1820 + 32'(i);
  endfunction
  function automatic logic [31:0] er(input int i);
    return 32'(5 + 2 * i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int i);
    pc   = epc(i);
    inst = einst(i);
    r    = er(i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pc = '0; inst = '0; r = '0;
    we = 1'b0; waddr = '0; wpc = '0; winst = '0; wr = '0;
    len = '0; start = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy",   32'(busy_a), 0);
    chk("rst_done",   32'(done_a), 0);
    chk("rst_pass",   32'(pass_a), 0);
    chk("rst_fail",   32'(fail_a), 0);
    chk("rst_cycles", 32'(cycles_a), 0);
    chk("rst_errpc",  err_pc_a, 0);
    rst = 1'b0;

    // Load golden trace
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wpc = epc(i); winst = einst(i); wr = er(i);
      tick();
    end
    we = 1'b0;

    // Full match, LEN=4: DONE after exactly 6 edges
    len = 6'd4; start = 1'b1;
    tick();
    start = 1'b0;
    present(0);
    tick();
    chk("match_busy_wait", 32'(busy_a), 1);
    chk("match_done_early", 32'(done_a), 0);
    for (int i = 0; i < 4; i++) begin
      present(i);
      tick();
      if (i == 2) chk("match_done_edge5", 32'(done_a), 0);
    end
    chk("match_pass",   32'(pass_a), 1);
    chk("match_done",   32'(done_a), 1);
    chk("match_fail",   32'(fail_a), 0);
    chk("match_busy",   32'(busy_a), 0);
    chk("match_cycles", 32'(cycles_a), 4);

    // INST mismatch at entry 2
    len = 6'd4; start = 1'b1;
    tick();
    start = 1'b0;
    present(0);
    tick();
    for (int i = 0; i < 3; i++) begin
      present(i);
      if (i == 2) inst = einst(2) ^ 32'h1;
      tick();
      if (i == 1) begin
        chk("inst_fail_early", 32'(fail_a), 0);
        chk("inst_busy_mid",   32'(busy_a), 1);
      end
    end
    chk("inst_fail",     32'(fail_a), 1);
    chk("inst_pass",     32'(pass_a), 0);
    chk("inst_done",     32'(done_a), 1);
    chk("inst_err_idx",  32'(err_idx_a), 2);
    chk("inst_err_fld",  32'(err_field_a), 32'b010);
    chk("inst_err_pc",   err_pc_a, 8);
    chk("inst_cycles",   32'(cycles_a), 3);

    // PC and R wrong at entry 0; R masked on the CHECK_R=0 instance
    len = 6'd4; start = 1'b1;
    pc = 32'h100; inst = einst(0); r = 32'hDEAD;
    tick();
    start = 1'b0;
    tick();
    chk("nr_fail",    32'(fail_b), 1);
    chk("nr_err_fld", 32'(err_field_b), 32'b001);
    chk("nr_err_idx", 32'(err_idx_b), 0);
    chk("nr_err_pc",  err_pc_b, 32'h100);
    tick();
    chk("r_err_fld",  32'(err_field_a), 32'b101);
    chk("r_err_idx",  32'(err_idx_a), 0);

    // LEN=0 passes on the edge after START, error info cleared
    len = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_pass",   32'(pass_a), 1);
    chk("len0_done",   32'(done_a), 1);
    chk("len0_fail",   32'(fail_a), 0);
    chk("len0_cycles", 32'(cycles_a), 0);
    chk("len0_errfld", 32'(err_field_a), 0);

    // LEN=40 clips to 32; WE and START during CHECK are ignored
    len = 6'd40; start = 1'b1;
    tick();
    start = 1'b0;
    present(0);
    tick();
    for (int i = 0; i < 32; i++) begin
      present(i);
      if (i == 3) begin
        we = 1'b1; waddr = 5'd25; wpc = 32'hBAD0; winst = 32'hBAD1; wr = 32'hBAD2;
      end
      if (i == 5) begin
        start = 1'b1; len = 6'd2;
      end
      tick();
      we = 1'b0; start = 1'b0;
      if (i == 30) begin
        chk("clip_busy_31", 32'(busy_a), 1);
        chk("clip_pass_31", 32'(pass_a), 0);
      end
    end
    chk("clip_pass",   32'(pass_a), 1);
    chk("clip_fail",   32'(fail_a), 0);
    chk("clip_cycles", 32'(cycles_a), 32);

    // Async reset mid-CHECK at idx 3, then rerun on retained memory
    len = 6'd8; start = 1'b1;
    tick();
    start = 1'b0;
    present(0);
    tick();
    for (int i = 0; i < 3; i++) begin
      present(i);
      tick();
    end
    chk("pre_rst_cycles", 32'(cycles_a), 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   32'(busy_a), 0);
    chk("arst_done",   32'(done_a), 0);
    chk("arst_pass",   32'(pass_a), 0);
    chk("arst_fail",   32'(fail_a), 0);
    chk("arst_cycles", 32'(cycles_a), 0);
    #2 rst = 1'b0;
    tick();
    len = 6'd8; start = 1'b1;
    tick();
    start = 1'b0;
    present(0);
    tick();
    for (int i = 0; i < 8; i++) begin
      present(i);
      tick();
    end
    chk("rerun_pass",   32'(pass_a), 1);
    chk("rerun_fail",   32'(fail_a), 0);
    chk("rerun_cycles", 32'(cycles_a), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
